// File: rtl/shared_dff_arbiter.sv
// shared_dff_arbiter
//   Round-robin write arbiter placed in front of a shared W-bit Q/QB register.
//   Each request is one write. In IDLE, a winner is picked from the pending
//   requests and its lane is latched. The next edge commits the latched data
//   to q/qb and emits a one-cycle grant. The shared register is written only
//   here, so qb always equals ~q.
//
//   Ports
//     clk    : clock, posedge
//     rst    : synchronous, active-high reset
//     req    : per-requester write request, level, held until granted
//     wdata  : request data, lane i is wdata[i*W +: W]
//     gnt    : one-hot grant pulse, registered, one cycle long
//     q, qb  : shared register value and its complement
//     owner  : index of the last granted requester
//     busy   : high while a latched write is pending
//     wcount : completed-write counter, wraps 255 -> 0
module shared_dff_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       wdata,
  output logic [N-1:0]         gnt,
  output logic [W-1:0]         q,
  output logic [W-1:0]         qb,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic [7:0]           wcount
);

  localparam int IW = $clog2(N);
  localparam int unsigned NU = N;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic [W-1:0]  dlat;

  logic [IW-1:0] idx;
  logic [IW-1:0] win;
  logic          found;
  logic [W-1:0]  win_data;
  logic [IW-1:0] sel_inc;

  // Rotating priority: scan from ptr upward, wrapping modulo N. The first
  // requester found wins.
  always_comb begin
    idx   = '0;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NU; k++) begin
      idx = IW'((32'(ptr) + k) % NU);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Lane mux for the winner's data.
  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NU; i++) begin
      if (win == IW'(i)) begin
        win_data = wdata[i*W +: W];
      end
    end
  end

  // Next pointer. It wraps at N-1, which also handles N values that are not
  // a power of two.
  always_comb begin
    if (sel == IW'(N - 1)) begin
      sel_inc = '0;
    end else begin
      sel_inc = sel + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      sel    <= '0;
      dlat   <= '0;
      q      <= '0;
      qb     <= '1;
      gnt    <= '0;
      owner  <= '0;
      busy   <= 1'b0;
      wcount <= '0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            sel   <= win;
            dlat  <= win_data;
            busy  <= 1'b1;
            state <= WRITE;
          end
        end
        WRITE: begin
          // The write is committed once latched. req and wdata are not
          // consulted here.
          q          <= dlat;
          qb         <= ~dlat;
          gnt[sel]   <= 1'b1;
          owner      <= sel;
          ptr        <= sel_inc;
          wcount     <= wcount + 8'd1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_dff_arbiter.sv
module tb_shared_dff_arbiter;

  localparam int N = 4;
  localparam int W = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic [W-1:0]   qb;
  logic [1:0]     owner;
  logic           busy;
  logic [7:0]     wcount;

  int total = 0;
  int bad   = 0;

  shared_dff_arbiter #(.N(N), .W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .wdata  (wdata),
    .gnt    (gnt),
    .q      (q),
    .qb     (qb),
    .owner  (owner),
    .busy   (busy),
    .wcount (wcount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model. It tracks one pending transaction record and applies the
  // arbitration rule as "smallest forward distance from the pointer".
  bit         model_valid = 1'b0;
  bit         m_pend;
  int         m_who;
  logic [W-1:0] m_data;
  int         m_ptr;
  logic [W-1:0] m_q;
  int         m_gnt;
  int         m_owner;
  int         m_cnt;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      m_pend = 0; m_who = 0; m_data = '0; m_ptr = 0;
      m_q = '0; m_gnt = 0; m_owner = 0; m_cnt = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (m_pend) begin
        m_q     = m_data;
        m_gnt   = 1 << m_who;
        m_owner = m_who;
        m_ptr   = (m_who + 1) % N;
        m_cnt   = (m_cnt + 1) % 256;
        m_pend  = 0;
      end else begin
        int best;
        int bestd;
        m_gnt = 0;
        best  = -1;
        bestd = N;
        for (int i = 0; i < N; i++) begin
          if (req[i]) begin
            int d;
            d = (i - m_ptr + N) % N;
            if (d < bestd) begin
              bestd = d;
              best  = i;
            end
          end
        end
        if (best >= 0) begin
          m_pend = 1;
          m_who  = best;
          m_data = wdata[best*W +: W];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      logic [W-1:0] mqb;
      mqb = ~m_q;
      check("q",      32'(q),      32'(m_q));
      check("qb",     32'(qb),     32'(mqb));
      check("gnt",    32'(gnt),    32'(m_gnt));
      check("owner",  32'(owner),  32'(m_owner));
      check("busy",   32'(busy),   32'(m_pend));
      check("wcount", 32'(wcount), 32'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [N-1:0] exp_g [5];
  logic [W-1:0] exp_q [5];

  initial begin
    rst   = 1'b1;
    req   = 4'b1111;
    wdata = 8'b11100100;
    @(negedge clk);

    // Reset held for two cycles with all requests asserted.
    tick(); tick();
    check("rst_q",      32'(q),      32'h0);
    check("rst_qb",     32'(qb),     32'h3);
    check("rst_gnt",    32'(gnt),    32'h0);
    check("rst_owner",  32'(owner),  32'h0);
    check("rst_busy",   32'(busy),   32'h0);
    check("rst_wcount", 32'(wcount), 32'h0);

    // Single request from requester 2 with data 10.
    rst   = 1'b0;
    req   = 4'b0100;
    wdata = 8'b00100000;
    tick();
    check("single_busy_e0", 32'(busy), 32'h1);
    tick();
    check("single_q",      32'(q),      32'h2);
    check("single_qb",     32'(qb),     32'h1);
    check("single_gnt",    32'(gnt),    32'h4);
    check("single_owner",  32'(owner),  32'h2);
    check("single_wcount", 32'(wcount), 32'h1);
    req = '0;
    tick();
    check("single_gnt_e2", 32'(gnt),  32'h0);
    check("single_busy_e2", 32'(busy), 32'h0);

    // Full contention from a fresh pointer.
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    req   = 4'b1111;
    wdata = 8'b11100100;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_q = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
    for (int k = 0; k < 5; k++) begin
      tick();
      check("cont_gnt_gap", 32'(gnt), 32'h0);
      tick();
      check("cont_gnt", 32'(gnt), 32'(exp_g[k]));
      check("cont_q",   32'(q),   32'(exp_q[k]));
    end
    req = '0;
    tick();

    // The pointer is now 1, so requester 3 is ahead of requester 0.
    req = 4'b1001;
    tick(); tick();
    check("wrap_first", 32'(gnt), 32'h8);
    req = 4'b0001;
    tick(); tick();
    check("wrap_second", 32'(gnt), 32'h1);
    req = '0;
    tick();

    // The write stays committed after req drops and the lane changes.
    req   = 4'b0010;
    wdata = 8'b00000100;
    tick();
    req   = '0;
    wdata = 8'b00001100;
    tick();
    check("commit_q",   32'(q),   32'h1);
    check("commit_gnt", 32'(gnt), 32'h2);
    tick();

    // Reset asserted on the WRITE edge aborts the write.
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    req   = 4'b0100;
    wdata = 8'b00100000;
    tick();
    check("abort_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    tick();
    check("abort_gnt",    32'(gnt),    32'h0);
    check("abort_q",      32'(q),      32'h0);
    check("abort_qb",     32'(qb),     32'h3);
    check("abort_wcount", 32'(wcount), 32'h0);
    rst = 1'b0;
    req = '0;
    tick();
    check("abort_gnt2", 32'(gnt), 32'h0);

    // 256 writes wrap the counter back to 0.
    req = 4'b0001;
    for (int g = 1; g <= 256; g++) begin
      tick(); tick();
      if (g == 255) check("wc_255", 32'(wcount), 32'd255);
      wdata[1:0] = W'($urandom);
    end
    check("wc_wrap", 32'(wcount), 32'd0);
    req = '0;
    tick();

    // Random traffic with the requester protocol honoured.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) begin
          if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
          else wdata[i*W +: W] = W'($urandom);
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          wdata[i*W +: W] = W'($urandom);
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
